// File: rtl/mesm6_pbus_pkg.sv
// Shared types for the MESM-6 peripheral bus arbiter: FSM states, op encoding
// and the default slave-timeout length.
package mesm6_pbus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } pbus_state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } pbus_op_t;

   localparam int PBUS_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mesm6_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the master that was not
// granted last wins.
module mesm6_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = (req == 2'b11) ? ~last_grant : req[1];
   end

endmodule

// File: rtl/mesm6_pbus_arbiter.sv
// Two-master arbiter for the MESM-6 peripheral register bus: one transaction at
// a time into a single slave, round-robin fair, with a bus-timeout error reply.
module mesm6_pbus_arbiter
   import mesm6_pbus_pkg::*;
#(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 48,
   parameter int TIMEOUT = PBUS_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_done,
   output logic              m0_err,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_done,
   output logic              m1_err,
   output logic [ADDR_W-1:0] s_addr,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_done,
   output logic              busy
);

   localparam int          CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   pbus_state_t       state_q, state_d;
   pbus_op_t          op_q;
   logic              gnt_id_q;
   logic              last_grant_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              gnt_valid;
   logic              gnt_id;
   logic              timed_out;

   mesm6_rr_arb2 u_rr (
      .req        ({m1_read | m1_write, m0_read | m0_write}),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   assign timed_out = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt_valid) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (s_done || timed_out) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q         <= OP_READ;
         gnt_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (gnt_valid) begin
               gnt_id_q <= gnt_id;
               addr_q   <= gnt_id ? m1_addr : m0_addr;
               wdata_q  <= gnt_id ? m1_wdata : m0_wdata;
               op_q     <= (gnt_id ? m1_write : m0_write) ? OP_WRITE : OP_READ;
               err_q    <= 1'b0;
               rdata_q  <= '0;
            end
            ISSUE: cnt_q <= '0;
            // A slave answer in the final timeout cycle still counts as a normal reply.
            WAIT: begin
               if (s_done) begin
                  rdata_q <= (op_q == OP_WRITE) ? '0 : s_rdata;
                  err_q   <= 1'b0;
               end else if (timed_out) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: last_grant_q <= gnt_id_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      s_addr   = addr_q;
      s_wdata  = wdata_q;
      s_read   = (state_q == ISSUE) && (op_q == OP_READ);
      s_write  = (state_q == ISSUE) && (op_q == OP_WRITE);
      busy     = (state_q != IDLE);
      m0_done  = (state_q == RESP) && !gnt_id_q;
      m1_done  = (state_q == RESP) &&  gnt_id_q;
      m0_err   = m0_done && err_q;
      m1_err   = m1_done && err_q;
      m0_rdata = m0_done ? rdata_q : '0;
      m1_rdata = m1_done ? rdata_q : '0;
   end

endmodule

// File: doc/mesm6_pbus_arbiter.md
Name: mesm6_pbus_arbiter

Overview:
- Two-master arbiter for the MESM-6 peripheral register bus: addr/read/write/wdata/rdata/done, as used by mesm6_gpio.
- Master 0 is the CPU. Master 1 is the debug/DMA port.
- Sequences one transaction at a time into a single peripheral slave using round-robin fairness.
- Supplies a bus-timeout response when the slave never answers.

Parameters:
- ADDR_W, 15, peripheral address width.
- DATA_W, 48, data word width.
- TIMEOUT, 16, cycles waited in WAIT for s_done before forcing an error response (minimum 2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- m0_addr / m1_addr  input  ADDR_W  master register address, held stable until done
- m0_read / m1_read  input  1  read request level
- m0_write / m1_write  input  1  write request level
- m0_wdata / m1_wdata  input  DATA_W  write data, held stable until done
- m0_rdata / m1_rdata  output  DATA_W  registered read data, valid while done=1
- m0_done / m1_done  output  1  one-cycle completion pulse
- m0_err / m1_err  output  1  one-cycle pulse coincident with done on timeout
- s_addr  output  ADDR_W  slave address
- s_read  output  1  slave read strobe
- s_write  output  1  slave write strobe
- s_wdata  output  DATA_W  slave write data
- s_rdata  input  DATA_W  slave read data (may be combinational on s_addr)
- s_done  input  1  slave completion
- busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - A master requests when read|write is high.
  - If both request, grant the master not granted last. last_grant resets to 1, so m0 wins the first tie.
  - On grant: latch addr, wdata, op (write wins if read and write are both high), and grant id. Go to ISSUE.
- ISSUE:
  - s_read or s_write = 1 for exactly one cycle. s_addr and s_wdata come from the latched values.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Strobes low. s_addr and s_wdata stay held.
  - Sample s_done every cycle. When s_done=1: capture s_rdata (zero on writes), go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1, go to RESP with rdata=0 and err flagged.
  - An s_done seen in the same cycle as the timeout wins: normal response, no err.
- RESP:
  - The granted master's done=1 for one cycle, with rdata held and err if flagged. Update last_grant.
  - Go to IDLE. Request inputs are ignored in RESP.
- Master rule: deassert the request in the cycle after done. A request still high in IDLE is a new transaction.
- Latency with a 1-cycle slave such as mesm6_gpio: request seen in IDLE cycle N, strobe at N+1, s_done at N+2, mX_done at N+3. Back-to-back throughput is 4 cycles per transaction.
- A stray s_done in IDLE, ISSUE or RESP is ignored.
- The ungranted master's done, err and rdata stay 0.
- Reset, including mid-transaction:
  - State goes to IDLE; all strobes, done and err go to 0; rdata registers and s_addr/s_wdata go to 0; last_grant goes to 1; counter goes to 0.
  - No response is delivered for the aborted transaction.
- busy is 0 at reset.

Decomposition:
- Package mesm6_pbus_pkg holds:
  - the state enum typedef pbus_state_t (IDLE/ISSUE/WAIT/RESP);
  - the op typedef (OP_READ/OP_WRITE);
  - the default TIMEOUT localparam.
- Sub-module mesm6_rr_arb2: combinational 2-way round-robin picker. Inputs are req[1:0] and last_grant; outputs are gnt_valid and gnt_id.
- FSM, latches and timeout counter stay in the top module.

Test Plan:
- m0 read addr 'o6 against a gpio model returning 48'h123456789ABC -> s_read pulses 1 cycle at N+1, m0_done at N+3, m0_rdata=48'h123456789ABC, m1_done stays 0.
- m0 and m1 write simultaneously from reset (wdata 'h1 / 'h2) -> m0 serviced first, then m1. Slave sees 'h1 then 'h2; done pulses 4 cycles apart.
- Both masters request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Slave never asserts s_done, TIMEOUT=16 -> mX_done and mX_err pulse together 17 cycles after ISSUE, rdata=0, then FSM returns to IDLE.
- Reset asserted during WAIT -> next cycle busy=0, no done pulse. A fresh m1 read afterwards completes normally in 3 cycles.
- s_done pulse injected while IDLE, plus read and write asserted together on m1 -> stray done ignored; the transaction issues s_write only.
